char_ram_arbiter: RTL and testbench
===================================

# char_ram_arbiter

Schedules the single-port character RAM between the display path and a host writer. The display side (text components issuing `addr` per pixel) owns the RAM throughout the visible area with zero added latency. Host writes are queued in a small FIFO and drained only during horizontal/vertical blanking. The block sits between the pixel counter and the character RAM, replacing the direct component-to-RAM address connection.

## Interface

- `ADDR_W`, 8, RAM address width.
- `DATA_W`, 8, RAM data width.
- `DEPTH`, 4, write FIFO depth (power of two, ≥2).
- `H_VIS`, 640, visible columns; `x >= H_VIS` is horizontal blanking.
- `V_VIS`, 480, visible lines; `y >= V_VIS` is vertical blanking.

Ports:

- `px_clk` in 1: pixel clock, the only clock.
- `reset` in 1: synchronous, active-high.
- `x` in 10: current screen column.
- `y` in 10: current screen line.
- `disp_addr` in ADDR_W: display read address (OR of component `addr` outputs).
- `disp_data` out ADDR_W→DATA_W: read data to components, one cycle after `disp_addr`.
- `wr_valid` in 1: host write request.
- `wr_ready` out 1: FIFO can accept.
- `wr_addr` in ADDR_W: host write address.
- `wr_data` in DATA_W: host write data.
- `ram_addr` out ADDR_W: RAM address.
- `ram_we` out 1: RAM write enable.
- `ram_wdata` out DATA_W: RAM write data.
- `ram_rdata` in DATA_W: RAM registered read output (1-cycle latency).
- `pending` out 1: FIFO non-empty.
- `level` out log2(DEPTH)+1: FIFO occupancy.

## Operation

- `blank = (x >= H_VIS) || (y >= V_VIS)`, combinational from current `x`/`y`.
- Display owner (`!blank`): `ram_addr = disp_addr`, `ram_we = 0`, `ram_wdata = 0`.
- Host owner (`blank`):
  - FIFO non-empty: `ram_addr` = head addr, `ram_wdata` = head data, `ram_we = 1`, head popped at clock edge.
  - FIFO empty: `ram_addr = disp_addr`, `ram_we = 0`.
- `disp_data = ram_rdata` passthrough; the arbiter adds no register on the read path.
- FIFO:
  - Push when `wr_valid && wr_ready`.
  - `wr_ready = (level < DEPTH)`, combinational from registered count; no bypass of a same-cycle pop.
  - Pop rate: at most one entry per blank cycle.
  - Entries are written to RAM in acceptance order. Later writes to the same address win.
- Simultaneous push and pop: `level` unchanged; pointers both advance.
- Full: `wr_ready = 0` even if a pop happens that cycle. `wr_valid` held by the host is accepted the next cycle.
- Pointers wrap modulo DEPTH. `level` is a separate counter, 0..DEPTH.
- Reset:
  - `level = 0`, pointers = 0, `pending = 0`, `wr_ready = 1`, `ram_we = 0`.
  - Queued writes are discarded, including a reset asserted mid-blanking.
  - While `reset` is high, `ram_we` is forced 0 regardless of `blank`.

## Timing

- Display read latency: `disp_addr` at cycle N → `disp_data` valid at N+1. This matches the components' one-cycle `active` delay.
- The last visible read (x=H_VIS-1) returns data at x=H_VIS. A write issued at x=H_VIS affects `ram_rdata` from x=H_VIS+1 only, so it is never displayed corrupt.
- Write latency: accepted at edge N, earliest RAM write at cycle N+1 if blank. Otherwise it waits for the first blank cycle.
- Throughput: DEPTH writes drained in DEPTH consecutive blank cycles. 160 horizontal-blank cycles per line ≫ DEPTH, so no write starves beyond one line.

## Structure

- `H_VIS`/`V_VIS` defaults and blanking macros go in `const.vh` alongside the colour constants.
- One sub-module: `wr_fifo` (synchronous FIFO, DEPTH×(ADDR_W+DATA_W), with `push`/`pop`/`level`/`full`/`empty`).
- The ownership mux is combinational in the top level.

## Test plan

- **Reset:** hold `reset` 3 cycles with `wr_valid=1`, x=700 → `ram_we=0`, `level=0`, `wr_ready=1`; first push at release+1.
- **Visible write:** at x=100, y=50 push (0x10,0x41) → `level=1`, `ram_we` stays 0 until x=640. At x=640, `ram_addr=0x10`, `ram_wdata=0x41`, `ram_we=1`; `level=0` next cycle.
- **Full:** in the visible area push 5 writes → 4 accepted, `wr_ready=0` at `level=4`. The 5th is accepted one cycle after the first blank pop. RAM writes appear in order on consecutive blank cycles.
- **Read latency:** visible area, `disp_addr` = 0x05 then 0x06 with RAM model holding 0xAA/0xBB → `disp_data` = 0xAA then 0xBB, one cycle later each. `ram_we` is never 1.
- **Simultaneous push/pop:** x=650, `level=2`, push → `level` stays 2; the ordering check passes.
- **Reset mid-drain:** y=490, `level=3`, assert `reset` after one pop → no further `ram_we`, `level=0`. The remaining two entries never reach the RAM.

Source files
------------

// File: rtl/char_ram_arbiter_pkg.sv
// char_ram_arbiter_pkg: screen geometry defaults, RAM owner type, blanking helper
package char_ram_arbiter_pkg;
  localparam int X_W = 10;
  localparam int H_VIS_DEF = 640;
  localparam int V_VIS_DEF = 480;
  typedef enum logic {OWN_DISP, OWN_HOST} owner_e;
  function automatic logic is_blank(input logic [X_W-1:0] x, input logic [X_W-1:0] y, input int hv, input int vv);
    return (int'(x) >= hv) || (int'(y) >= vv);
  endfunction
endpackage

// File: rtl/char_ram_arbiter_wr_fifo.sv
// wr_fifo: synchronous FIFO of DEPTH x W with push/pop, occupancy level, full and empty flags
module wr_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_dout,
  output logic [AW:0]   o_level,
  output logic          o_full,
  output logic          o_empty
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_level;
  logic          w_push, w_pop;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = r_level == (AW+1)'(DEPTH);
  assign o_empty = r_level == '0;
  assign o_level = r_level;
  assign o_dout  = r_mem[r_rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_din;
endmodule

// File: rtl/char_ram_arbiter.sv
// char_ram_arbiter: shares the char RAM between display reads (visible area) and FIFO-queued host writes (blanking)
module char_ram_arbiter
  import char_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int H_VIS  = H_VIS_DEF,
  parameter int V_VIS  = V_VIS_DEF,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic              px_clk,
  input  logic              reset,
  input  logic [X_W-1:0]    x,
  input  logic [X_W-1:0]    y,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              pending,
  output logic [LW-1:0]     level
);
  logic                     w_blank, w_full, w_empty;
  logic [ADDR_W-1:0]        w_head_addr;
  logic [DATA_W-1:0]        w_head_data;
  owner_e                   w_owner;
  wr_fifo #(.W(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk    (px_clk),
    .rst    (reset),
    .i_push (wr_valid && wr_ready),
    .i_pop  (ram_we),
    .i_din  ({wr_addr, wr_data}),
    .o_dout ({w_head_addr, w_head_data}),
    .o_level(level),
    .o_full (w_full),
    .o_empty(w_empty)
  );
  assign w_blank   = is_blank(x, y, H_VIS, V_VIS);
  assign wr_ready  = !w_full;
  assign pending   = !w_empty;
  assign disp_data = ram_rdata;
  // reset gates ownership so a half-drained queue never writes while being discarded
  always_comb begin
    w_owner   = (w_blank && !w_empty && !reset) ? OWN_HOST : OWN_DISP;
    ram_we    = w_owner == OWN_HOST;
    ram_addr  = ram_we ? w_head_addr : disp_addr;
    ram_wdata = ram_we ? w_head_data : '0;
  end
endmodule

// File: tb/tb_char_ram_arbiter.sv
// tb_char_ram_arbiter: directed self-checking bench with RAM model and write log
module tb_char_ram_arbiter;
  logic       px_clk = 0, reset;
  logic [9:0] x, y;
  logic [7:0] disp_addr, disp_data, wr_addr, wr_data, ram_addr, ram_wdata, ram_rdata;
  logic       wr_valid, wr_ready, ram_we, pending;
  logic [2:0] level;
  logic [7:0] mem [256];
  logic [15:0] wlog [$];
  int n_chk = 0, n_err = 0;
  char_ram_arbiter dut (
    .px_clk(px_clk), .reset(reset), .x(x), .y(y), .disp_addr(disp_addr), .disp_data(disp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pending(pending), .level(level)
  );
  always #5 px_clk = ~px_clk;
  always @(posedge px_clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wlog.push_back({ram_addr, ram_wdata});
    end
    ram_rdata <= mem[ram_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge px_clk);
    #1;
  endtask
  task automatic chk_log(input int idx, input logic [15:0] exp);
    chk($sformatf("log[%0d]", idx), (idx < wlog.size()) ? 32'(wlog[idx]) : 32'hDEAD, 32'(exp));
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[5] = 8'hAA;
    mem[6] = 8'hBB;
    reset = 1; x = 700; y = 0; disp_addr = 0; wr_valid = 1; wr_addr = 8'h77; wr_data = 8'h99;
    tick(3);
    chk("rst_we", ram_we, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", wr_ready, 1);
    chk("rst_pending", pending, 0);
    reset = 0;
    #1 chk("rel_level", level, 0);
    tick();
    chk("rel_push_level", level, 1);
    chk("rel_we", ram_we, 1);
    chk("rel_addr", ram_addr, 8'h77);
    chk("rel_wdata", ram_wdata, 8'h99);
    wr_valid = 0;
    tick();
    chk("rel_drain", level, 0);
    // write in visible area waits for blanking
    x = 100; y = 50; wr_valid = 1; wr_addr = 8'h10; wr_data = 8'h41;
    tick();
    wr_valid = 0;
    chk("vis_level", level, 1);
    for (int i = 0; i < 3; i++) begin
      x = 10'(101 + i);
      #1 chk("vis_we", ram_we, 0);
      tick();
    end
    x = 640;
    #1;
    chk("blank_we", ram_we, 1);
    chk("blank_addr", ram_addr, 8'h10);
    chk("blank_wdata", ram_wdata, 8'h41);
    tick();
    chk("blank_level", level, 0);
    chk("blank_pending", pending, 0);
    // fill the FIFO, fifth write waits behind the full flag
    x = 100;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1; wr_addr = 8'(8'h20 + i); wr_data = 8'(8'hC0 + i);
      #1 chk("full_ready", wr_ready, (i < 4) ? 1 : 0);
      if (i < 4) tick();
    end
    chk("full_level", level, 4);
    x = 640;
    #1;
    chk("full_pop_ready", wr_ready, 0);
    chk("full_pop_addr", ram_addr, 8'h20);
    tick();
    chk("full_after_pop", level, 3);
    chk("full_ready2", wr_ready, 1);
    tick();
    wr_valid = 0;
    chk("full_pushpop", level, 3);
    tick(3);
    chk("full_drained", level, 0);
    for (int i = 0; i < 5; i++) chk_log(2 + i, {8'(8'h20 + i), 8'(8'hC0 + i)});
    // display read latency
    x = 200; disp_addr = 8'h05;
    #1 chk("rd_addr", ram_addr, 8'h05);
    tick();
    chk("rd_data0", disp_data, 8'hAA);
    disp_addr = 8'h06;
    tick();
    chk("rd_data1", disp_data, 8'hBB);
    chk("rd_nowrite", wlog.size(), 7);
    // simultaneous push and pop in blanking
    x = 100;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1; wr_addr = 8'(8'h30 + i); wr_data = 8'(8'hD0 + i);
      tick();
    end
    chk("sim_level", level, 2);
    x = 650; wr_addr = 8'h32; wr_data = 8'hD2;
    tick();
    wr_valid = 0;
    chk("sim_keep", level, 2);
    tick(2);
    chk("sim_drained", level, 0);
    for (int i = 0; i < 3; i++) chk_log(7 + i, {8'(8'h30 + i), 8'(8'hD0 + i)});
    // reset while draining discards the rest
    x = 100; y = 100;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1; wr_addr = 8'(8'h40 + i); wr_data = 8'(8'hE0 + i);
      tick();
    end
    wr_valid = 0;
    chk("mid_level", level, 3);
    y = 490;
    tick();
    chk("mid_one_pop", level, 2);
    reset = 1;
    #1 chk("mid_rst_we", ram_we, 0);
    tick();
    chk("mid_rst_level", level, 0);
    reset = 0;
    tick(4);
    chk("mid_no_more", wlog.size(), 11);
    chk_log(10, 16'h40E0);
    chk("mid_we", ram_we, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
